// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX operand forwarding,
// MEM store-data bypass, load-use detection and a long-latency-unit register scoreboard.

module hazard_forward_sel #(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] memRd,
  input  logic            memRegWrite,
  input  logic [RA_W-1:0] wbRd,
  input  logic            wbRegWrite,
  output logic [1:0]      sel
);
  logic memHit, wbHit;
  assign memHit = memRegWrite && (memRd != '0) && (memRd == src);
  assign wbHit  = wbRegWrite && (wbRd != '0) && (wbRd == src);
  // MEM is the younger producer, so it masks WB; select is never 11
  assign sel    = {memHit, wbHit && !memHit};
endmodule

module hazard_forward_unit #(
  parameter int RA_W    = 5,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  ID_rs1,
  input  logic [RA_W-1:0]  ID_rs2,
  input  logic [RA_W-1:0]  ID_rd,
  input  logic             ID_RegWrite,
  input  logic             ID_LongOp,
  input  logic [RA_W-1:0]  EX_rs1,
  input  logic [RA_W-1:0]  EX_rs2,
  input  logic [RA_W-1:0]  EX_rd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic             EX_LongOp,
  input  logic [RA_W-1:0]  MEM_rs2,
  input  logic [RA_W-1:0]  MEM_rd,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemWrite,
  input  logic [RA_W-1:0]  WB_rd,
  input  logic             WB_RegWrite,
  input  logic             LU_done,
  input  logic [RA_W-1:0]  LU_rd,
  input  logic             perf_clr,
  output logic [1:0]       BusAFW,
  output logic [1:0]       BusBFW,
  output logic             DiSrc,
  output logic             stall,
  output logic             lu_full,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int NUM_REGS = 2 ** RA_W;
  localparam int NUM_SRC  = 2;
  localparam int CW       = $clog2(MAX_OUT + 1);

  logic [NUM_SRC-1:0][RA_W-1:0] exSrc;
  logic [NUM_SRC-1:0][1:0]      fwdSel;

  assign exSrc = {EX_rs2, EX_rs1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : gSrc
    hazard_forward_sel #(.RA_W(RA_W)) uSel (
      .src         (exSrc[g]),
      .memRd       (MEM_rd),
      .memRegWrite (MEM_RegWrite),
      .wbRd        (WB_rd),
      .wbRegWrite  (WB_RegWrite),
      .sel         (fwdSel[g])
    );
  end

  assign BusAFW = fwdSel[0];
  assign BusBFW = fwdSel[1];
  assign DiSrc  = WB_RegWrite && (WB_rd != '0) && (WB_rd == MEM_rs2) && MEM_MemWrite;

  // EX_RegWrite is unused: long results bypass forwarding and the load check uses MemRead
  logic unusedExRw;
  assign unusedExRw = EX_RegWrite;

  logic [NUM_REGS-1:0] pend, pendNext;
  logic [CW-1:0]       outCnt;
  logic                issueSet, doneClr;

  assign issueSet = EX_LongOp && (EX_rd != '0);
  assign doneClr  = LU_done && pend[LU_rd];

  // Clear before set so a same-edge retire/reissue of one register stays pending
  always_comb begin
    pendNext = pend;
    if (doneClr)  pendNext[LU_rd] = 1'b0;
    if (issueSet) pendNext[EX_rd] = 1'b1;
    pendNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      outCnt <= '0;
    end else begin
      pend <= pendNext;
      if (issueSet && !doneClr)      outCnt <= outCnt + 1'b1;
      else if (doneClr && !issueSet) outCnt <= outCnt - 1'b1;
    end
  end

  assign lu_full = (outCnt == CW'(MAX_OUT));

  logic loadUse, rawLong, wawLong, structLong;
  logic exLongHit1, exLongHit2, exLongHitD;

  assign exLongHit1 = EX_LongOp && (EX_rd == ID_rs1);
  assign exLongHit2 = EX_LongOp && (EX_rd == ID_rs2);
  assign exLongHitD = EX_LongOp && (EX_rd == ID_rd);

  assign loadUse    = EX_MemRead && (EX_rd != '0) && ((EX_rd == ID_rs1) || (EX_rd == ID_rs2));
  assign rawLong    = ((ID_rs1 != '0) && (pend[ID_rs1] || exLongHit1)) ||
                      ((ID_rs2 != '0) && (pend[ID_rs2] || exLongHit2));
  assign wawLong    = ID_RegWrite && (ID_rd != '0) && (pend[ID_rd] || exLongHitD);
  // Conservative: a same-cycle LU_done is not credited toward a free slot
  assign structLong = ID_LongOp && (lu_full || ((outCnt == CW'(MAX_OUT - 1)) && EX_LongOp));

  assign stall = loadUse || rawLong || wawLong || structLong;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_cycles <= '0;
    else if (perf_clr)                 stall_cycles <= '0;
    else if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: driver pushes expected values into a queue,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_hazard_forward_unit;
  localparam int RA_W    = 5;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 5;

  localparam int S_A = 0, S_B = 1, S_DI = 2, S_ST = 3, S_FULL = 4, S_CNT = 5;

  logic clk, rst_n;
  logic [RA_W-1:0] ID_rs1, ID_rs2, ID_rd, EX_rs1, EX_rs2, EX_rd, MEM_rs2, MEM_rd, WB_rd, LU_rd;
  logic ID_RegWrite, ID_LongOp, EX_RegWrite, EX_MemRead, EX_LongOp;
  logic MEM_RegWrite, MEM_MemWrite, WB_RegWrite, LU_done, perf_clr;
  logic [1:0] BusAFW, BusBFW;
  logic DiSrc, stall, lu_full;
  logic [CNT_W-1:0] stall_cycles;

  hazard_forward_unit #(.RA_W(RA_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
    .ID_RegWrite(ID_RegWrite), .ID_LongOp(ID_LongOp),
    .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_LongOp(EX_LongOp),
    .MEM_rs2(MEM_rs2), .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite), .MEM_MemWrite(MEM_MemWrite),
    .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite),
    .LU_done(LU_done), .LU_rd(LU_rd), .perf_clr(perf_clr),
    .BusAFW(BusAFW), .BusBFW(BusBFW), .DiSrc(DiSrc), .stall(stall),
    .lu_full(lu_full), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } expT;

  expT expQ[$];
  int  nChecks = 0;
  int  nPass   = 0;

  function automatic void chk(input string name, input int sel, input int val);
    expT e;
    e.name = name; e.sel = sel; e.val = val;
    expQ.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      expT e;
      int act;
      e = expQ.pop_front();
      case (e.sel)
        S_A:     act = int'(BusAFW);
        S_B:     act = int'(BusBFW);
        S_DI:    act = int'(DiSrc);
        S_ST:    act = int'(stall);
        S_FULL:  act = int'(lu_full);
        default: act = int'(stall_cycles);
      endcase
      nChecks++;
      if (act == e.val) nPass++;
      else $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
    end
  end

  always @(posedge clk) begin
    if (rst_n && EX_LongOp)
      assert (!lu_full) else $error("long op issued while unit full");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clrIn();
    ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0; ID_RegWrite = 0; ID_LongOp = 0;
    EX_rs1 = '0; EX_rs2 = '0; EX_rd = '0; EX_RegWrite = 0; EX_MemRead = 0; EX_LongOp = 0;
    MEM_rs2 = '0; MEM_rd = '0; MEM_RegWrite = 0; MEM_MemWrite = 0;
    WB_rd = '0; WB_RegWrite = 0; LU_done = 0; LU_rd = '0; perf_clr = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clrIn();
    cyc();
    MEM_RegWrite = 1; MEM_rd = 2; EX_rs1 = 2;
    chk("rst_fwdA", S_A, 2); chk("rst_stall", S_ST, 0);
    chk("rst_full", S_FULL, 0); chk("rst_cnt", S_CNT, 0);
    cyc(); rst_n = 1'b1; clrIn();

    // forwarding priority and x0 handling
    cyc(); MEM_rd = 5; WB_rd = 5; MEM_RegWrite = 1; WB_RegWrite = 1; EX_rs1 = 5; EX_rs2 = 5;
    chk("fwdA_mem", S_A, 2); chk("fwdB_mem", S_B, 2);
    cyc(); MEM_RegWrite = 0;
    chk("fwdA_wb", S_A, 1);
    cyc(); WB_rd = 0;
    chk("fwdA_rf", S_A, 0);
    cyc(); MEM_RegWrite = 1; MEM_rd = 0; WB_rd = 5; EX_rs1 = 6;
    chk("fwdB_wb_memx0", S_B, 1); chk("fwdA_nohit", S_A, 0);

    // store data bypass
    cyc(); clrIn(); WB_rd = 7; WB_RegWrite = 1; MEM_rs2 = 7; MEM_MemWrite = 1;
    chk("disrc_on", S_DI, 1);
    cyc(); MEM_MemWrite = 0;
    chk("disrc_nowr", S_DI, 0);
    cyc(); WB_rd = 0; MEM_rs2 = 0; MEM_MemWrite = 1;
    chk("disrc_x0", S_DI, 0);

    // load-use
    cyc(); clrIn(); EX_MemRead = 1; EX_rd = 3; ID_rs2 = 3;
    chk("lduse_stall", S_ST, 1); chk("lduse_cnt0", S_CNT, 0);
    cyc(); EX_MemRead = 0;
    chk("lduse_bubble", S_ST, 0); chk("lduse_cnt1", S_CNT, 1);
    cyc(); EX_MemRead = 1; EX_rd = 0; ID_rs2 = 0;
    chk("lduse_x0", S_ST, 0);

    // long op RAW/WAW and release timing
    cyc(); clrIn(); EX_LongOp = 1; EX_rd = 9; ID_rs1 = 9;
    chk("long_issue_raw", S_ST, 1);
    cyc(); EX_LongOp = 0; EX_rd = 0;
    chk("long_pend_raw", S_ST, 1);
    cyc(); ID_rs1 = 0; ID_RegWrite = 1; ID_rd = 9;
    chk("long_waw", S_ST, 1);
    cyc(); ID_RegWrite = 0; ID_rd = 0; ID_rs1 = 9; LU_done = 1; LU_rd = 9;
    chk("long_done_cycle", S_ST, 1);
    cyc(); LU_done = 0; LU_rd = 0;
    chk("long_released", S_ST, 0); chk("long_cnt", S_CNT, 5);

    // structural: fill the long unit
    cyc(); clrIn(); EX_LongOp = 1; EX_rd = 1;
    chk("full_c1", S_FULL, 0);
    cyc(); EX_rd = 2;
    cyc(); EX_rd = 3; ID_LongOp = 1;
    chk("struct_cnt2", S_ST, 0);
    cyc(); EX_rd = 4;
    chk("struct_cnt3_issue", S_ST, 1); chk("full_c4", S_FULL, 0);
    cyc(); EX_LongOp = 0; EX_rd = 0;
    chk("full_set", S_FULL, 1); chk("struct_full", S_ST, 1);
    cyc(); LU_done = 1; LU_rd = 2;
    chk("struct_nocredit", S_ST, 1); chk("full_done_cycle", S_FULL, 1);
    cyc(); LU_rd = 7; ID_LongOp = 0;
    chk("full_cleared", S_FULL, 0); chk("struct_free", S_ST, 0); chk("full_cnt", S_CNT, 8);
    cyc(); LU_rd = 0; EX_LongOp = 1; EX_rd = 5;
    chk("full_c8", S_FULL, 0);
    cyc(); EX_LongOp = 0; EX_rd = 0; LU_rd = 1;
    chk("full_ignored_done", S_FULL, 1);
    cyc(); LU_rd = 3; EX_LongOp = 1; EX_rd = 6; ID_LongOp = 1;
    chk("full_c10", S_FULL, 0); chk("struct_c10", S_ST, 1);
    cyc(); LU_done = 0; LU_rd = 0; EX_LongOp = 0; EX_rd = 0;
    chk("full_sameedge", S_FULL, 0); chk("struct_cnt3_idle", S_ST, 0);
    cyc(); ID_LongOp = 0; ID_rs1 = 3;
    chk("pend3_cleared", S_ST, 0);
    cyc(); ID_rs1 = 6;
    chk("pend6_set", S_ST, 1);
    for (int i = 0; i < 11; i++) cyc();
    ID_rs1 = 4;
    chk("pre_rst_stall", S_ST, 1); chk("pre_rst_cnt", S_CNT, 20);

    // asynchronous reset mid-cycle
    cyc(); #1 rst_n = 1'b0;
    chk("arst_stall", S_ST, 0); chk("arst_full", S_FULL, 0); chk("arst_cnt", S_CNT, 0);
    cyc(); rst_n = 1'b1; clrIn();

    // perf_clr priority and saturation
    cyc(); EX_MemRead = 1; EX_rd = 3; ID_rs1 = 3;
    chk("pc_stall", S_ST, 1); chk("pc_cnt0", S_CNT, 0);
    cyc(); perf_clr = 1;
    chk("pc_cnt1", S_CNT, 1);
    cyc(); perf_clr = 0; EX_MemRead = 0;
    chk("pc_cleared", S_CNT, 0);
    cyc(); EX_MemRead = 1;
    for (int i = 0; i < 40; i++) cyc();
    EX_MemRead = 0;
    chk("sat_cnt", S_CNT, 31); chk("sat_nostall", S_ST, 0);
    cyc();
    chk("sat_hold", S_CNT, 31);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      nChecks++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding controller for the five-stage pipeline. It generates EX-stage operand forwarding selects and the MEM-stage store-data bypass, and detects load-use hazards. It also keeps a register scoreboard for a multi-cycle long-latency unit (MUL/DIV) and produces the IF/ID stall. It sits beside the ID/EX/MEM/WB pipeline registers and drives their stall and bubble controls.

## Interface
Parameters:
- RA_W, 5, register address width; NUM_REGS = 2**RA_W.
- MAX_OUT, 4, maximum outstanding long-latency ops (1..NUM_REGS-1).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_rs1, ID_rs2, ID_rd  in  RA_W  ID-stage register addresses.
- ID_RegWrite, ID_LongOp  in  1  ID instruction writes rd / is a long-latency op.
- EX_rs1, EX_rs2, EX_rd  in  RA_W  EX-stage register addresses.
- EX_RegWrite, EX_MemRead, EX_LongOp  in  1  EX-stage controls; EX_LongOp=1 means the op is issued to the long unit this cycle.
- MEM_rs2, MEM_rd  in  RA_W; MEM_RegWrite, MEM_MemWrite  in  1.
- WB_rd  in  RA_W; WB_RegWrite  in  1.
- LU_done  in  1; LU_rd  in  RA_W  long unit writes its result to the register file this cycle.
- perf_clr  in  1  synchronous clear of stall_cycles.
- BusAFW, BusBFW  out  2  EX operand select: 10 = MEM result, 01 = WB result, 00 = register file.
- DiSrc  out  1  MEM store data taken from the WB result.
- stall  out  1  hold PC and IF/ID, insert a bubble into ID/EX.
- lu_full  out  1  outstanding count == MAX_OUT.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

## Operation
- Forwarding (combinational), per EX source s:
  - MEM hit = MEM_RegWrite and MEM_rd != 0 and MEM_rd == s. MEM hit takes priority.
  - WB hit = WB_RegWrite and WB_rd != 0 and WB_rd == s. A WB hit applies only when there is no MEM hit.
  - Select bits are one-hot or zero, never 11.
- DiSrc = WB_RegWrite and WB_rd != 0 and WB_rd == MEM_rs2 and MEM_MemWrite.
- Long ops deassert RegWrite in MEM/WB. Their results never come from the forwarding path; they reach the register file only on LU_done. The register file is write-before-read.
- Scoreboard: pend[NUM_REGS-1:0] and out_cnt (width clog2(MAX_OUT+1)).
  - Set: EX_LongOp and EX_rd != 0 sets pend[EX_rd] and increments out_cnt.
  - Clear: LU_done and pend[LU_rd] clears the bit and decrements out_cnt. LU_done on a non-pending register or on x0 is ignored.
  - Same edge, different registers: both take effect; out_cnt is unchanged.
  - Same edge, same register: the bit stays set; out_cnt is unchanged.
  - pend[0] is constant 0.
- stall = OR of:
  - Load-use: EX_MemRead and EX_rd != 0 and EX_rd equals ID_rs1 or ID_rs2.
  - Long RAW: ID_rs1 or ID_rs2 (non-zero) is pending, or equals EX_rd while EX_LongOp=1.
  - Long WAW: ID_RegWrite, ID_rd != 0, and ID_rd is pending or equals EX_rd while EX_LongOp=1.
  - Structural: ID_LongOp and (lu_full, or out_cnt == MAX_OUT-1 with EX_LongOp=1). This check uses only registered state and does not credit a same-cycle LU_done.
- stall_cycles: increments on each edge where stall=1 and the counter is not all-ones, then saturates. perf_clr=1 loads 0 and takes priority over the increment.

## Timing
- Forward selects, DiSrc and stall are combinational from the current inputs and registered state; zero latency.
- Issue at edge t: pend is visible from cycle t+1.
- LU_done at cycle t: the dependent ID instruction is still stalled in cycle t and released in cycle t+1.
- Load-use: exactly one stall cycle, because the bubble clears EX_MemRead.
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - pend=0, out_cnt=0, stall_cycles=0, lu_full=0.
  - Combinational outputs follow their inputs.
  - Any in-flight long ops are discarded; the long unit is reset by the same rst_n.
- An overflowing issue (EX_LongOp while lu_full) cannot occur by construction. The verification bench asserts this.

## Test plan
- MEM_rd=WB_rd=5, both RegWrite=1, EX_rs1=5 -> BusAFW=10. Drop MEM_RegWrite -> 01. Set rd=0 -> 00.
- WB_rd=7, WB_RegWrite=1, MEM_rs2=7, MEM_MemWrite=1 -> DiSrc=1. MEM_MemWrite=0 -> DiSrc=0.
- EX_MemRead=1, EX_rd=3, ID_rs2=3 -> stall=1 for one cycle; then bubble (EX_MemRead=0) -> stall=0; stall_cycles=1.
- Long op issued with rd=9, ID_rs1=9 held:
  - stall=1 in the issue cycle and every cycle after.
  - LU_done with LU_rd=9 at cycle t -> stall falls in cycle t+1; pend[9]=0.
- With MAX_OUT=4, issue 4 long ops to x1..x4 -> lu_full=1, and an ID long op stalls. LU_done for x2 -> lu_full=0 on the next cycle.
- Assert rst_n=0 asynchronously with 3 ops pending and stall_cycles=20 -> pend, out_cnt and stall_cycles read 0 immediately; ID_rs1=1 no longer stalls.
